// File: rtl/interrupt_controller_if.sv
// ============================================================================
// Module   : interrupt_controller_if
// Brief    : CPU bus bundle between a 68000-style master and the interrupt
//            controller (strobe, select, address, data and terminations).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface interrupt_controller_if;
    logic       AS_n;
    logic       RW;
    logic       CS_n;
    logic [2:0] FC;
    logic [2:0] ADDR;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       DTACK_n;
    logic       VPA_n;
    logic       BERR_n;

    modport master (
        output AS_n, RW, CS_n, FC, ADDR, DATA_IN,
        input  DATA_OUT, DTACK_n, VPA_n, BERR_n
    );

    modport slave (
        input  AS_n, RW, CS_n, FC, ADDR, DATA_IN,
        output DATA_OUT, DTACK_n, VPA_n, BERR_n
    );
endinterface

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module   : interrupt_controller
// Brief    : Prioritised IPL encoder for external level IRQs plus a periodic
//            timer, with register window and IACK handling on a 68000 bus.
//            Define VECTORED_IACK_EN to enable vectored IACK (CTRL.b1, VBASE).
// Revision : 1.0
// ============================================================================
`default_nettype none

module interrupt_controller #(
    parameter int          NUM_SRC          = 5,
    parameter int          TIMER_LEVEL      = 6,
    parameter logic [23:0] TIMER_RELOAD_RST = 24'd399999
) (
    input  wire                     CLK,
    input  wire                     RST,
    input  wire [NUM_SRC-1:0]       IRQ_IN,
    interrupt_controller_if.slave   bus,
    output logic [2:0]              IPL_n
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_DTACK = 3'd1;
    localparam logic [2:0] c_ST_VPA   = 3'd2;
    localparam logic [2:0] c_ST_BERR  = 3'd3;
    localparam logic [2:0] c_ST_WAIT  = 3'd4;

    localparam logic [2:0] c_TLVL     = 3'(TIMER_LEVEL);
    localparam logic [2:0] c_FC_CPU   = 3'b111;

    logic [2:0]  r_state;
    logic [7:0]  r_mask;
    logic        r_tmr_en;
    logic [23:0] r_reload;
    logic [23:0] r_count;
    logic        r_tmr_flag;
    logic [7:0]  r_data_out;
    logic [2:0]  r_ipl_n;

    logic [7:0]  w_ext;
    logic [7:0]  w_tmr_vec;
    logic [7:0]  w_req;
    logic [7:0]  w_pend;
    logic [2:0]  w_top;
    logic        w_idle;
    logic        w_iack;
    logic        w_reg;
    logic        w_write;
    logic        w_lvl_pend;
    logic        w_iack_ok;
    logic        w_reload_wr;
    logic [23:0] w_reload_nxt;
    logic        w_expire;
    logic        w_tmr_clr;
    logic        w_vec_mode;
    logic [7:0]  w_vbase;
    logic [7:0]  w_rd_data;

    // Source i drives level i+1; levels beyond NUM_SRC have no external input.
    assign w_ext[0] = 1'b0;
    for (genvar gl = 1; gl < 8; gl++) begin : g_lvl
        if (gl - 1 < NUM_SRC) begin : g_ext
            assign w_ext[gl] = IRQ_IN[gl-1];
        end else begin : g_none
            assign w_ext[gl] = 1'b0;
        end
    end

    always_comb begin
        w_tmr_vec         = 8'h00;
        w_tmr_vec[c_TLVL] = r_tmr_flag;
    end

    assign w_req  = w_ext | w_tmr_vec;
    // Level 7 is non-maskable; level 0 never exists.
    assign w_pend = w_req & (r_mask | 8'h80) & 8'hFE;

    always_comb begin
        w_top = 3'd0;
        for (int l = 1; l < 8; l++) begin
            if (w_pend[l]) begin
                w_top = 3'(l);
            end
        end
    end

    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_iack      = !bus.AS_n && (bus.FC == c_FC_CPU);
    assign w_reg       = !bus.AS_n && !bus.CS_n && (bus.FC != c_FC_CPU);
    assign w_write     = w_idle && w_reg && !bus.RW;
    assign w_lvl_pend  = w_pend[bus.ADDR];
    assign w_iack_ok   = w_idle && w_iack && w_lvl_pend;
    assign w_reload_wr = w_write && (bus.ADDR inside {3'd2, 3'd3, 3'd4});
    assign w_expire    = r_tmr_en && (r_count == 24'd0);
    assign w_tmr_clr   = (w_write && (bus.ADDR == 3'd0) && bus.DATA_IN[c_TLVL])
                       || (w_iack_ok && (bus.ADDR == c_TLVL));

    always_comb begin
        w_reload_nxt = r_reload;
        case (bus.ADDR)
            3'd2:    w_reload_nxt[7:0]   = bus.DATA_IN;
            3'd3:    w_reload_nxt[15:8]  = bus.DATA_IN;
            3'd4:    w_reload_nxt[23:16] = bus.DATA_IN;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mask   <= 8'h00;
            r_tmr_en <= 1'b1;
            r_reload <= TIMER_RELOAD_RST;
        end else if (w_write) begin
            case (bus.ADDR)
                3'd1:    r_mask   <= bus.DATA_IN;
                3'd5:    r_tmr_en <= bus.DATA_IN[0];
                default: ;
            endcase
            if (w_reload_wr) begin
                r_reload <= w_reload_nxt;
            end
        end
    end

`ifdef VECTORED_IACK_EN
    logic       r_vec_mode;
    logic [7:0] r_vbase;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vec_mode <= 1'b0;
            r_vbase    <= 8'h40;
        end else if (w_write) begin
            if (bus.ADDR == 3'd5) begin
                r_vec_mode <= bus.DATA_IN[1];
            end
            if (bus.ADDR == 3'd6) begin
                r_vbase <= bus.DATA_IN;
            end
        end
    end

    assign w_vec_mode = r_vec_mode;
    assign w_vbase    = r_vbase;
`else
    assign w_vec_mode = 1'b0;
    assign w_vbase    = 8'h00;
`endif

    // Expiry sets the flag even when a W1C or IACK clear lands on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count    <= TIMER_RELOAD_RST;
            r_tmr_flag <= 1'b0;
        end else begin
            if (w_reload_wr) begin
                r_count <= w_reload_nxt;
            end else if (r_tmr_en) begin
                r_count <= (r_count == 24'd0) ? r_reload : r_count - 24'd1;
            end
            if (w_expire) begin
                r_tmr_flag <= 1'b1;
            end else if (w_tmr_clr) begin
                r_tmr_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        case (bus.ADDR)
            3'd0:    w_rd_data = w_req;
            3'd1:    w_rd_data = r_mask;
            3'd2:    w_rd_data = r_reload[7:0];
            3'd3:    w_rd_data = r_reload[15:8];
            3'd4:    w_rd_data = r_reload[23:16];
            3'd5:    w_rd_data = {6'b000000, w_vec_mode, r_tmr_en};
            3'd6:    w_rd_data = w_vbase;
            default: w_rd_data = 8'h00;
        endcase
    end

    // Reset lands in WAIT so a cycle cut short by reset is ignored until AS_n rises.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= c_ST_WAIT;
            r_data_out <= 8'h00;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_iack) begin
                        if (!w_lvl_pend) begin
                            r_state <= c_ST_BERR;
                        end else if (w_vec_mode) begin
                            r_state    <= c_ST_DTACK;
                            r_data_out <= w_vbase + {5'b00000, bus.ADDR};
                        end else begin
                            r_state <= c_ST_VPA;
                        end
                    end else if (w_reg) begin
                        r_state <= c_ST_DTACK;
                        if (bus.RW) begin
                            r_data_out <= w_rd_data;
                        end
                    end
                end
                c_ST_DTACK, c_ST_VPA, c_ST_BERR, c_ST_WAIT: begin
                    if (bus.AS_n) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ipl_n <= 3'b111;
        end else begin
            r_ipl_n <= ~w_top;
        end
    end

    assign IPL_n        = r_ipl_n;
    assign bus.DATA_OUT = r_data_out;
    assign bus.DTACK_n  = (r_state != c_ST_DTACK);
    assign bus.VPA_n    = (r_state != c_ST_VPA);
    assign bus.BERR_n   = (r_state != c_ST_BERR);

endmodule

`default_nettype wire
